// File: rtl/coil_pkg.sv
// Shared definitions for the coil H-bridge PWM driver: FSM encoding,
// PWM period geometry and gate-vector bit positions.
package coil_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEAD      = 2'd1,
        DRIVE_POS = 2'd2,
        DRIVE_NEG = 2'd3
    } state_t;

    localparam int PWM_SLOTS = 16;

    // Gate vector layout {P_HI, P_LO, N_HI, N_LO}
    localparam int G_P_HI = 3;
    localparam int G_P_LO = 2;
    localparam int G_N_HI = 1;
    localparam int G_N_LO = 0;

    function automatic logic is_drive(input state_t s);
        return (s == DRIVE_POS) || (s == DRIVE_NEG);
    endfunction

endpackage

// File: rtl/coil_pwm_timebase.sv
// PWM timebase: prescale counter p and 16-slot counter c, with period
// boundary and first-cycle strobes.
module coil_pwm_timebase
    import coil_pkg::*;
#(
    parameter int PRESCALE = 8
) (
    input  logic       CLK_IN,
    input  logic       rst_n,
    input  logic       run,
    input  logic       clear,
    output logic [3:0] c,
    output logic       boundary,
    output logic       first
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
    localparam logic [3:0]    C_LAST = 4'(PWM_SLOTS - 1);

    logic [PW-1:0] p;

    always_ff @(posedge CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            p <= '0;
            c <= '0;
        end else if (clear) begin
            p <= '0;
            c <= '0;
        end else if (run) begin
            if (p == P_LAST) begin
                p <= '0;
                c <= c + 4'd1;
            end else begin
                p <= p + 1'b1;
            end
        end
    end

    assign boundary = run && (p == P_LAST) && (c == C_LAST);
    assign first    = run && (p == '0) && (c == '0);

endmodule

// File: rtl/coil_pwm_driver.sv
// Coil H-bridge driver: amplitude -> PWM duty, current flag -> polarity,
// inputs shadowed at period boundaries, dead time on enable and reversal.
module coil_pwm_driver
    import coil_pkg::*;
#(
    parameter int PRESCALE  = 8,
    parameter int DEAD_TIME = 4
) (
    input  logic       CLK_IN,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [3:0] amplitude,
    input  logic       positive_current,
    output logic       HB_P_HI,
    output logic       HB_P_LO,
    output logic       HB_N_HI,
    output logic       HB_N_LO,
    output logic       period_start,
    output logic       active
);

    localparam int DW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_TIME - 1);

    state_t        state, state_n;
    logic [DW-1:0] dead_cnt;
    logic [3:0]    duty;
    logic          pol;
    logic          load_dead, latch_all, latch_duty;
    logic [3:0]    c;
    logic          boundary, first;
    logic          drive, tb_clear;
    logic [3:0]    gates_q, gates_n;

    assign drive    = is_drive(state);
    assign tb_clear = !enable || !drive;

    coil_pwm_timebase #(.PRESCALE(PRESCALE)) u_timebase (
        .CLK_IN   (CLK_IN),
        .rst_n    (rst_n),
        .run      (drive),
        .clear    (tb_clear),
        .c        (c),
        .boundary (boundary),
        .first    (first)
    );

    always_comb begin
        state_n    = state;
        load_dead  = 1'b0;
        latch_all  = 1'b0;
        latch_duty = 1'b0;
        if (!enable) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_n   = DEAD;
                    load_dead = 1'b1;
                    latch_all = 1'b1;
                end
                DEAD: begin
                    if (dead_cnt == '0) state_n = pol ? DRIVE_POS : DRIVE_NEG;
                end
                DRIVE_POS, DRIVE_NEG: begin
                    if (boundary) begin
                        if (positive_current == pol) begin
                            latch_duty = 1'b1;
                        end else begin
                            state_n   = DEAD;
                            load_dead = 1'b1;
                            latch_all = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dead_cnt <= '0;
            duty     <= '0;
            pol      <= 1'b0;
        end else begin
            state <= state_n;
            if (load_dead)                          dead_cnt <= DEAD_LAST;
            else if (!enable)                       dead_cnt <= '0;
            else if (state == DEAD && dead_cnt != '0) dead_cnt <= dead_cnt - 1'b1;
            if (latch_all) begin
                duty <= amplitude;
                pol  <= positive_current;
            end else if (latch_duty) begin
                duty <= amplitude;
            end
        end
    end

    // High side is on while the slot index is below the duty; the low side
    // of the opposite leg stays on for the whole drive period.
    always_comb begin
        gates_n = '0;
        case (state)
            DRIVE_POS: begin
                gates_n[G_P_HI] = (c < duty);
                gates_n[G_N_LO] = 1'b1;
            end
            DRIVE_NEG: begin
                gates_n[G_N_HI] = (c < duty);
                gates_n[G_P_LO] = 1'b1;
            end
            default: gates_n = '0;
        endcase
    end

    always_ff @(posedge CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            gates_q      <= '0;
            period_start <= 1'b0;
            active       <= 1'b0;
        end else begin
            gates_q      <= gates_n;
            period_start <= first;
            active       <= drive;
        end
    end

    assign HB_P_HI = gates_q[G_P_HI];
    assign HB_P_LO = gates_q[G_P_LO];
    assign HB_N_HI = gates_q[G_N_HI];
    assign HB_N_LO = gates_q[G_N_LO];

endmodule

// File: tb/tb_coil_pwm_driver.sv
// Bench for coil_pwm_driver: period-level segment table, directed corner
// sequences and randomized traffic against a period-index reference model.
module tb_coil_pwm_driver;

    localparam int PRESCALE  = 2;
    localparam int DEAD_TIME = 3;
    localparam int PERIOD    = 16 * PRESCALE;

    logic       CLK_IN = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] amplitude;
    logic       positive_current;
    logic       HB_P_HI, HB_P_LO, HB_N_HI, HB_N_LO, period_start, active;

    coil_pwm_driver #(.PRESCALE(PRESCALE), .DEAD_TIME(DEAD_TIME)) dut (
        .CLK_IN           (CLK_IN),
        .rst_n            (rst_n),
        .enable           (enable),
        .amplitude        (amplitude),
        .positive_current (positive_current),
        .HB_P_HI          (HB_P_HI),
        .HB_P_LO          (HB_P_LO),
        .HB_N_HI          (HB_N_HI),
        .HB_N_LO          (HB_N_LO),
        .period_start     (period_start),
        .active           (active)
    );

    always #5 CLK_IN = ~CLK_IN;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0=off, 1=dead, 2=driving; m_t is the cycle index
    // within the PWM period, so on-time is simply m_t < duty*PRESCALE.
    int m_mode, m_dead_left, m_duty, m_t;
    logic m_pol;

    int cnt_phi, cnt_nhi, cnt_zero, cnt_ps;

    task automatic model_reset();
        m_mode = 0; m_dead_left = 0; m_duty = 0; m_t = 0; m_pol = 1'b0;
    endtask

    function automatic logic [5:0] model_out();
        logic on;
        logic [5:0] o;
        o = '0;
        if (m_mode == 2) begin
            on = (m_t < m_duty * PRESCALE);
            if (m_pol) o[5:2] = {on, 1'b0, 1'b0, 1'b1};
            else       o[5:2] = {1'b0, 1'b1, on, 1'b0};
            o[1] = (m_t == 0);
            o[0] = 1'b1;
        end
        return o;
    endfunction

    task automatic model_step(input logic en, input logic [3:0] amp, input logic pc);
        if (!en) begin
            m_mode = 0; m_t = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_dead_left = DEAD_TIME; m_duty = int'(amp); m_pol = pc;
        end else if (m_mode == 1) begin
            m_dead_left--;
            if (m_dead_left == 0) begin m_mode = 2; m_t = 0; end
        end else if (m_t == PERIOD - 1) begin
            m_t = 0;
            if (pc == m_pol) m_duty = int'(amp);
            else begin m_mode = 1; m_dead_left = DEAD_TIME; m_duty = int'(amp); m_pol = pc; end
        end else begin
            m_t++;
        end
    endtask

    function automatic logic [5:0] obs();
        return {HB_P_HI, HB_P_LO, HB_N_HI, HB_N_LO, period_start, active};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, compare 1 time unit later.
    task automatic step(input logic en, input logic [3:0] amp, input logic pc);
        logic [5:0] exp_o;
        enable = en; amplitude = amp; positive_current = pc;
        @(posedge CLK_IN);
        exp_o = model_out();
        model_step(en, amp, pc);
        #1;
        chk("outputs_vs_model", int'(obs()), int'(exp_o));
        n_checks++;
        if ((HB_P_HI & HB_P_LO) | (HB_N_HI & HB_N_LO) | (HB_P_HI & HB_N_HI)) begin
            n_fail++;
            $display("FAIL shoot_through: gates=%b", obs());
        end
        cnt_phi  += int'(HB_P_HI);
        cnt_nhi  += int'(HB_N_HI);
        cnt_zero += int'({HB_P_HI, HB_P_LO, HB_N_HI, HB_N_LO} == 4'b0);
        cnt_ps   += int'(period_start);
    endtask

    typedef struct {
        logic       en;
        logic [3:0] amp;
        logic       pc;
        int         len;
        int         e_phi;
        int         e_nhi;
        int         e_zero;
        int         e_ps;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int first_n;
        int found;

        // Segments are aligned so each one covers whole or half periods.
        vecs[0]  = '{1'b1, 4'd4,  1'b1, 36, 8,  0, 4, 1}; // idle + 3 dead + period 1
        vecs[1]  = '{1'b1, 4'd4,  1'b1, 32, 8,  0, 0, 1};
        vecs[2]  = '{1'b1, 4'd4,  1'b1, 16, 8,  0, 0, 1}; // first half
        vecs[3]  = '{1'b1, 4'd12, 1'b1, 16, 0,  0, 0, 0}; // amp change mid-period
        vecs[4]  = '{1'b1, 4'd12, 1'b1, 32, 24, 0, 0, 1};
        vecs[5]  = '{1'b1, 4'd4,  1'b1, 16, 16, 0, 0, 1}; // duty 12 period
        vecs[6]  = '{1'b1, 4'd4,  1'b0, 16, 8,  0, 0, 0}; // reversal requested mid-period
        vecs[7]  = '{1'b1, 4'd4,  1'b0, 35, 0,  8, 3, 1}; // 3 dead + negative period
        vecs[8]  = '{1'b1, 4'd0,  1'b1, 32, 0,  8, 0, 1};
        vecs[9]  = '{1'b1, 4'd0,  1'b1, 35, 0,  0, 3, 1}; // 3 dead + duty 0 positive
        vecs[10] = '{1'b1, 4'd15, 1'b1, 32, 0,  0, 0, 1};
        vecs[11] = '{1'b1, 4'd15, 1'b1, 32, 30, 0, 0, 1}; // duty 15 period

        rst_n = 1'b0; enable = 1'b0; amplitude = '0; positive_current = 1'b0;
        model_reset();
        #1;
        chk("reset_outputs", int'(obs()), 0);
        repeat (2) @(posedge CLK_IN);
        #3 rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            cnt_phi = 0; cnt_nhi = 0; cnt_zero = 0; cnt_ps = 0;
            for (int k = 0; k < vecs[i].len; k++) step(vecs[i].en, vecs[i].amp, vecs[i].pc);
            chk($sformatf("seg%0d_p_hi_cycles", i),  cnt_phi,  vecs[i].e_phi);
            chk($sformatf("seg%0d_n_hi_cycles", i),  cnt_nhi,  vecs[i].e_nhi);
            chk($sformatf("seg%0d_all_off", i),      cnt_zero, vecs[i].e_zero);
            chk($sformatf("seg%0d_period_start", i), cnt_ps,   vecs[i].e_ps);
        end

        // Enable drop during a high pulse
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            step(1'b1, 4'd15, 1'b1);
            if (HB_P_HI) found = 1;
        end
        chk("find_pulse_for_drop", found, 1);
        step(1'b0, 4'd15, 1'b1);
        step(1'b0, 4'd15, 1'b1);
        chk("drop_gates_off", int'({HB_P_HI, HB_P_LO, HB_N_HI, HB_N_LO}), 0);
        chk("drop_active_off", int'(active), 0);
        repeat (3) step(1'b0, 4'd15, 1'b1);

        // Re-enable: idle latency plus full dead time before any gate
        first_n = -1;
        for (int n = 1; n <= 10; n++) begin
            step(1'b1, 4'd4, 1'b1);
            if (first_n < 0 && {HB_P_HI, HB_P_LO, HB_N_HI, HB_N_LO} != 4'b0) first_n = n;
        end
        chk("reenable_first_gate_edge", first_n, 1 + DEAD_TIME + 1);

        // Asynchronous reset while P_HI is high
        found = 0;
        for (int k = 0; k < 80 && !found; k++) begin
            step(1'b1, 4'd4, 1'b1);
            if (HB_P_HI) found = 1;
        end
        chk("find_pulse_for_reset", found, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'(obs()), 0);
        model_reset();
        #1 rst_n = 1'b1;
        repeat (4) step(1'b0, 4'd9, 1'b1);
        chk("post_reset_idle", int'(obs()), 0);

        // Randomized traffic
        positive_current = 1'b1;
        for (int k = 0; k < 2500; k++) begin
            logic en, pc;
            en = ($urandom_range(0, 59) != 0);
            pc = ($urandom_range(0, 69) == 0) ? ~positive_current : positive_current;
            step(en, 4'($urandom_range(0, 15)), pc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/coil_pwm_driver.md
Name: coil_pwm_driver

Overview:
- Downstream stage of the MRI-dust receive FSM.
- Consumes the decoded 4-bit amplitude and the positive/negative current flag, and drives the four gates of the coil H-bridge.
- Amplitude becomes a PWM duty cycle; the current flag selects bridge polarity.
- Both inputs are shadow-latched only at PWM period boundaries, and a dead-time interval is inserted on every polarity reversal and on enable.

Parameters:
PRESCALE, 8, clock cycles per PWM slot (>=1)
DEAD_TIME, 4, clock cycles with all gates off before driving a polarity (>=1)

Ports:
CLK_IN  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  level; 1 = drive coil, 0 = all gates off
amplitude  input  4  requested duty, in slots of 16 per period
positive_current  input  1  1 = positive polarity, 0 = negative
HB_P_HI  output  1  P-leg high-side gate
HB_P_LO  output  1  P-leg low-side gate
HB_N_HI  output  1  N-leg high-side gate
HB_N_LO  output  1  N-leg low-side gate
period_start  output  1  one-cycle pulse on the first cycle of each PWM period
active  output  1  1 while in DRIVE_POS or DRIVE_NEG

Behaviour:
- Reset, asynchronous on rst_n low: state IDLE; counters, duty and polarity shadows = 0; all gate outputs, period_start and active = 0.
- Counters:
  - Prescale counter p runs 0..PRESCALE-1; slot counter c is 4 bits, 0..15.
  - Both advance only in drive states: p increments every cycle; when p==PRESCALE-1, p<=0 and c<=c+1, wrapping 15->0.
  - Period = 16*PRESCALE cycles. Boundary = drive state && p==PRESCALE-1 && c==15.
- States:
  - IDLE:
    - enable=1 -> DEAD; latch amplitude -> duty, positive_current -> pol; load dead counter.
  - DEAD:
    - Counts DEAD_TIME cycles.
    - On the last cycle, go to DRIVE_POS (pol=1) or DRIVE_NEG (pol=0), with p=0 and c=0.
  - DRIVE_POS / DRIVE_NEG, at each boundary, sample both inputs:
    - Same polarity: duty<=amplitude; the next period starts.
    - Different polarity: latch both inputs, go to DEAD.
  - enable=0 in any state: -> IDLE next cycle, counters cleared. This overrides the boundary and dead-time logic.
- Duty: pwm_on = (c < duty), so high-side on-time = duty*PRESCALE cycles per period.
  - duty 0: never on.
  - duty 15: on for 15 of 16 slots.
- Gate decode:
  - DRIVE_POS: P_HI=pwm_on, N_LO=1, P_LO=N_HI=0.
  - DRIVE_NEG: N_HI=pwm_on, P_LO=1, N_HI/P_LO mirror of DRIVE_POS, P_HI=N_LO=0.
  - IDLE, DEAD: all 0.
- Gate outputs are registered from the current state/counters: 1-cycle latency.
- period_start and active are registered with the same 1-cycle alignment as the gates.
- Dead-time guarantee:
  - On a polarity reversal, all four gates are 0 for exactly DEAD_TIME consecutive cycles between the last old-polarity cycle and the first new-polarity cycle.
  - At the boundary c==15 and duty<=15, so the high side is already off.
- Invariants, at all times:
  - never P_HI&P_LO; never N_HI&N_LO; never P_HI&N_HI.
  - never any gate high while state is IDLE/DEAD (after the 1-cycle latency).
- Amplitude or polarity changes mid-period have no effect until the next boundary.
- Enable drop mid-pulse: gates 0 within 2 clock edges.
- Enable re-assert: a full DEAD_TIME interval is always served.

Decomposition:
- Shared package coil_pkg:
  - state encoding localparams IDLE=0, DEAD=1, DRIVE_POS=2, DRIVE_NEG=3;
  - PWM_SLOTS=16;
  - gate bit indices for a 4-bit gate vector {P_HI, P_LO, N_HI, N_LO}.
- One sub-module, coil_pwm_timebase:
  - contains p and c, parameterised by PRESCALE;
  - inputs: run, clear;
  - outputs: c, boundary strobe, first-cycle strobe.
- The top level holds the FSM, dead counter, shadows and gate registers.

Test Plan (PRESCALE=2, DEAD_TIME=3):
- Reset: rst_n low while driving P_HI=1 -> all gates, active and period_start 0 immediately, without a clock edge; stay 0 after release with enable=0.
- Start: enable=1, positive_current=1, amplitude=4:
  - first period_start after 3 dead cycles;
  - P_HI high 8 cycles of each 32-cycle period; N_LO constantly 1; P_LO=N_HI=0.
- Shadowing: amplitude 4->12 at mid-period -> current period keeps 8 high cycles; next period 24 high cycles.
- Reversal: positive_current 1->0 mid-period (amplitude=4):
  - current period completes;
  - all gates 0 for exactly 3 cycles;
  - then P_LO=1 and N_HI high 8 of 32 cycles;
  - checker asserts no shoot-through throughout.
- Extremes: amplitude=0 -> HB_P_HI never high, N_LO=1; amplitude=15 -> HB_P_HI high 30 of 32 cycles, low the last 2.
- Enable drop: enable 1->0 during a high pulse -> all gates 0 within 2 edges, active=0. Re-enable -> 3-cycle dead gap before any gate rises.
